// File: rtl/sum_of_n_seq.sv
// Iterative series accumulator: sum of 1..N or sum of squares 1..N, one term per clock.
// The start/done handshake is described next to the port list below.
module sum_of_n_seq #(
  parameter int N_WIDTH = 4,
  parameter int S_WIDTH = 3 * N_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_WIDTH-1:0] n,
  input  logic               mode,
  output logic [S_WIDTH-1:0] sum,
  output logic               busy,
  output logic               done,
  output logic               ovf,
  output logic [1:0]         state_dbg
);

  // Handshake: start is accepted on any rising edge where state is IDLE or DONE
  // (ready = !busy). n and mode are captured only on that edge. done stays high,
  // with sum/ovf frozen, until the next accepted start or reset.

  localparam int IW = N_WIDTH + 1;
  localparam int TW = 2 * IW;
  localparam int WW = S_WIDTH + TW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [S_WIDTH-1:0] acc, acc_nxt;
  logic [IW-1:0]      i, i_nxt;
  logic [N_WIDTH-1:0] n_reg, n_reg_nxt;
  logic               mode_reg, mode_reg_nxt;
  logic               ovf_reg, ovf_nxt;

  logic [TW-1:0]      i_ext;
  logic [TW-1:0]      i_sq;
  logic [TW-1:0]      term;
  logic [WW-1:0]      acc_wide;
  logic               last_term;

  assign i_ext     = {{(TW - IW){1'b0}}, i};
  assign i_sq      = i_ext * i_ext;
  assign term      = mode_reg ? i_sq : i_ext;
  // Full-width add: any bit at or above S_WIDTH flags overflow (term or carry).
  assign acc_wide  = {{(WW - S_WIDTH){1'b0}}, acc} + {{(WW - TW){1'b0}}, term};
  assign last_term = (i == {1'b0, n_reg});

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      i        <= '0;
      n_reg    <= '0;
      mode_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      i        <= i_nxt;
      n_reg    <= n_reg_nxt;
      mode_reg <= mode_reg_nxt;
      ovf_reg  <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    acc_nxt      = acc;
    i_nxt        = i;
    n_reg_nxt    = n_reg;
    mode_reg_nxt = mode_reg;
    ovf_nxt      = ovf_reg;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt    = RUN;
          n_reg_nxt    = n;
          mode_reg_nxt = mode;
          acc_nxt      = '0;
          i_nxt        = IW'(1);
          ovf_nxt      = 1'b0;
        end
      end
      RUN: begin
        if (n_reg == '0) begin
          state_nxt = DONE;
        end else begin
          acc_nxt = acc_wide[S_WIDTH-1:0];
          ovf_nxt = ovf_reg | (|acc_wide[WW-1:S_WIDTH]);
          i_nxt   = i + IW'(1);
          if (last_term) state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sum       = acc;
  assign ovf       = ovf_reg;
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_sum_of_n_seq.sv
// Directed bench for sum_of_n_seq: default instance plus a 6-bit-result instance for wrap/overflow.
module tb_sum_of_n_seq;

  logic       clk;
  logic       rst;
  logic       start_a, start_b;
  logic [3:0] n_a, n_b;
  logic       mode_a, mode_b;
  logic [11:0] sum_a;
  logic [5:0]  sum_b;
  logic       busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
  logic [1:0] st_a, st_b;

  int total = 0;
  int bad   = 0;

  sum_of_n_seq dut (
    .clk(clk), .rst(rst), .start(start_a), .n(n_a), .mode(mode_a),
    .sum(sum_a), .busy(busy_a), .done(done_a), .ovf(ovf_a), .state_dbg(st_a)
  );

  sum_of_n_seq #(.N_WIDTH(4), .S_WIDTH(6)) dut6 (
    .clk(clk), .rst(rst), .start(start_b), .n(n_b), .mode(mode_b),
    .sum(sum_b), .busy(busy_b), .done(done_b), .ovf(ovf_b), .state_dbg(st_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver: one accepted start, then count busy cycles until the run ends
  task automatic run(input int sel, input int nv, input int mv,
                     input int exp_sum, input int exp_ovf, input string tag);
    int cnt;
    int exp_busy;
    exp_busy = (nv == 0) ? 1 : nv;
    if (sel == 0) begin
      start_a = 1'b1; n_a = 4'(nv); mode_a = mv[0];
    end else begin
      start_b = 1'b1; n_b = 4'(nv); mode_b = mv[0];
    end
    tick();
    start_a = 1'b0; start_b = 1'b0;
    n_a = 4'($urandom_range(0, 15)); mode_a = 1'($urandom_range(0, 1));
    n_b = 4'($urandom_range(0, 15)); mode_b = 1'($urandom_range(0, 1));
    cnt = 0;
    while (((sel == 0) ? busy_a : busy_b) && cnt < 100) begin
      cnt++;
      tick();
    end
    check({tag, "_busy"}, cnt, exp_busy);
    if (sel == 0) begin
      check({tag, "_done"}, done_a, 1);
      check({tag, "_sum"},  sum_a, exp_sum);
      check({tag, "_ovf"},  ovf_a, exp_ovf);
    end else begin
      check({tag, "_done"}, done_b, 1);
      check({tag, "_sum"},  sum_b, exp_sum);
      check({tag, "_ovf"},  ovf_b, exp_ovf);
    end
  endtask

  // expected sums hand-computed: N(N+1)/2 for N = 0..15
  int tri_tab [16] = '{0, 1, 3, 6, 10, 15, 21, 28, 36, 45, 55, 66, 78, 91, 105, 120};

  initial begin
    int cnt;
    rst = 1'b1;
    start_a = 1'b0; n_a = '0; mode_a = 1'b0;
    start_b = 1'b0; n_b = '0; mode_b = 1'b0;
    tick(); tick(); tick();
    check("rst_sum",   sum_a, 0);
    check("rst_busy",  busy_a, 0);
    check("rst_done",  done_a, 0);
    check("rst_ovf",   ovf_a, 0);
    check("rst_state", st_a, 0);
    rst = 1'b0;
    tick();
    check("idle_hold_done", done_a, 0);

    run(0, 4, 0, 10, 0, "n4");
    tick(); tick(); tick();
    check("done_hold_done", done_a, 1);
    check("done_hold_sum",  sum_a, 10);
    check("done_state",     st_a, 2);

    for (int k = 0; k < 16; k++) run(0, k, 0, tri_tab[k], 0, $sformatf("sweep%0d", k));

    run(0, 15, 1, 1240, 0, "sq15");
    run(0, 3, 1, 14, 0, "sq3");
    run(0, 0, 0, 0, 0, "n0");

    // start and operand changes during RUN must not disturb the run
    start_a = 1'b1; n_a = 4'd10; mode_a = 1'b0;
    tick();
    check("restart_done_drop", done_a, 0);
    check("restart_busy",      busy_a, 1);
    start_a = 1'b0;
    tick(); tick();
    start_a = 1'b1; n_a = 4'd2; mode_a = 1'b1;
    tick();
    start_a = 1'b0;
    cnt = 3;
    while (busy_a && cnt < 100) begin
      cnt++;
      tick();
    end
    check("ign_busy", cnt, 10);
    check("ign_sum",  sum_a, 55);
    check("ign_done", done_a, 1);

    // second run aborted by reset mid-computation
    start_a = 1'b1; n_a = 4'd10; mode_a = 1'b0;
    tick();
    start_a = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    check("mid_sum",  sum_a, 15);
    check("mid_busy", busy_a, 1);
    rst = 1'b1;
    start_a = 1'b1;
    tick();
    rst = 1'b0;
    start_a = 1'b0;
    check("abort_state", st_a, 0);
    check("abort_sum",   sum_a, 0);
    check("abort_done",  done_a, 0);
    check("abort_busy",  busy_a, 0);
    check("abort_ovf",   ovf_a, 0);

    run(1, 15, 0, 56, 1, "w6_n15");
    run(1, 3, 0, 6, 0, "w6_n3");
    run(1, 7, 1, 12, 1, "w6_sq7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
